// File: rtl/regfile_scoreboard_if.sv
// ----------------------------------------------------------------------------
// regfile_scoreboard_if
//
// Bundles the decode/writeback/issue signals of the register file scoreboard.
//
//   master modport : pipeline side (decode read indices, writeback port,
//                    issue port); observes read data and hazard status.
//   slave modport  : register file side.
//
// Signals:
//   ra, rb        read indices A/B                  (master -> slave)
//   bus_a, bus_b  combinational read data A/B       (slave -> master)
//   we, rw, bus_w writeback enable, index, data     (master -> slave)
//   issue_valid   instruction leaves decode         (master -> slave)
//   issue_rd      its destination index             (master -> slave)
//   busy_a/busy_b read index has an unsatisfied producer
//   hazard        busy_a | busy_b | WAW on issue_rd
//   pending_cnt   registered popcount of pending bits
//   r_last        stored contents of the highest register (no bypass)
// ----------------------------------------------------------------------------
interface regfile_scoreboard_if #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 3
);
    logic [ADDR_W-1:0] ra;
    logic [ADDR_W-1:0] rb;
    logic [DATA_W-1:0] bus_a;
    logic [DATA_W-1:0] bus_b;
    logic              we;
    logic [ADDR_W-1:0] rw;
    logic [DATA_W-1:0] bus_w;
    logic              issue_valid;
    logic [ADDR_W-1:0] issue_rd;
    logic              busy_a;
    logic              busy_b;
    logic              hazard;
    logic [ADDR_W:0]   pending_cnt;
    logic [DATA_W-1:0] r_last;

    modport master (
        output ra, rb, we, rw, bus_w, issue_valid, issue_rd,
        input  bus_a, bus_b, busy_a, busy_b, hazard, pending_cnt, r_last
    );

    modport slave (
        input  ra, rb, we, rw, bus_w, issue_valid, issue_rd,
        output bus_a, bus_b, busy_a, busy_b, hazard, pending_cnt, r_last
    );
endinterface : regfile_scoreboard_if

// File: rtl/regfile_scoreboard.sv
// ----------------------------------------------------------------------------
// regfile_scoreboard
//
// Clocked NREGS x DATA_W register file with two combinational read ports,
// one writeback port, optional same-cycle write-to-read bypass, optional
// hard-wired zero register, and a per-register pending-write scoreboard
// used by the hazard unit.
//
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset; clears storage and scoreboard
//   rf     regfile_scoreboard_if.slave (read, writeback, issue, status)
//
// Parameters:
//   DATA_W    register width
//   ADDR_W    index width, NREGS = 2**ADDR_W
//   ZERO_REG  1: register 0 reads 0 and ignores writes and issues
//   BYPASS    1: a same-cycle writeback is forwarded to the read ports
// ----------------------------------------------------------------------------
module regfile_scoreboard #(
    parameter int DATA_W   = 16,
    parameter int ADDR_W   = 3,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1
) (
    input logic                 clk,
    input logic                 rst_n,
    regfile_scoreboard_if.slave rf
);
    localparam int NREGS = 2 ** ADDR_W;
    localparam int CNT_W = ADDR_W + 1;

    typedef logic [ADDR_W-1:0] idx_t;
    typedef logic [DATA_W-1:0] data_t;
    typedef logic [CNT_W-1:0]  cnt_t;

    data_t              regs [NREGS];
    logic [NREGS-1:0]   pending_q;
    logic [NREGS-1:0]   pending_d;
    cnt_t               pending_cnt_q;
    cnt_t               pending_cnt_d;

    logic wr_valid;
    logic set_valid;
    logic cnt_inc;
    logic cnt_dec;
    logic issue_busy;

    // An index is "live" unless it is the hard-wired zero register.
    function automatic logic is_live(input idx_t idx);
        return (ZERO_REG == 0) || (idx != '0);
    endfunction

    assign wr_valid  = rf.we & is_live(rf.rw);
    assign set_valid = rf.issue_valid & is_live(rf.issue_rd);

    // ------------------------------------------------------------------
    // Storage
    // ------------------------------------------------------------------
    // NOTE: the array is reset explicitly because reads of never-written
    // registers must return 0 after reset; this keeps it in flops rather
    // than an SRAM macro, which is acceptable at this size.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREGS; i++) begin
                // NOTE: state is always updated with non-blocking assignments
                // so every flop samples the pre-edge values of its inputs.
                regs[i] <= '0;
            end
        end else if (wr_valid) begin
            regs[rf.rw] <= rf.bus_w;
        end
    end

    // ------------------------------------------------------------------
    // Read ports: zero register, then bypass, then storage.
    // ------------------------------------------------------------------
    always_comb begin
        // NOTE: the output is assigned a default first so no path through
        // the conditionals can leave it unassigned and infer a latch.
        rf.bus_a = regs[rf.ra];
        if (!is_live(rf.ra)) begin
            rf.bus_a = '0;
        end else if ((BYPASS != 0) && rf.we && (rf.rw == rf.ra)) begin
            rf.bus_a = rf.bus_w;
        end
    end

    always_comb begin
        rf.bus_b = regs[rf.rb];
        if (!is_live(rf.rb)) begin
            rf.bus_b = '0;
        end else if ((BYPASS != 0) && rf.we && (rf.rw == rf.rb)) begin
            rf.bus_b = rf.bus_w;
        end
    end

    assign rf.r_last = regs[NREGS-1];

    // ------------------------------------------------------------------
    // Hazard status. A producer writing back this cycle satisfies its
    // consumers whether or not BYPASS is on; with BYPASS off the hazard
    // unit is expected to stall one more cycle on its own.
    // ------------------------------------------------------------------
    assign rf.busy_a = is_live(rf.ra) & pending_q[rf.ra]
                       & ~(wr_valid && (rf.rw == rf.ra));
    assign rf.busy_b = is_live(rf.rb) & pending_q[rf.rb]
                       & ~(wr_valid && (rf.rw == rf.rb));
    assign issue_busy = rf.issue_valid & pending_q[rf.issue_rd]
                        & ~(wr_valid && (rf.rw == rf.issue_rd));
    assign rf.hazard = rf.busy_a | rf.busy_b | issue_busy;

    // ------------------------------------------------------------------
    // Scoreboard next state. Clear is applied before set so that a new
    // producer issuing while the old one writes back keeps the bit set.
    // ------------------------------------------------------------------
    always_comb begin
        pending_d = pending_q;
        if (wr_valid) begin
            pending_d[rf.rw] = 1'b0;
        end
        if (set_valid) begin
            pending_d[rf.issue_rd] = 1'b1;
        end
    end

    // Count only real 0->1 and 1->0 transitions so pending_cnt stays equal
    // to the popcount without an adder tree. A clear that loses to a set
    // on the same index is not a transition.
    assign cnt_inc = set_valid & ~pending_q[rf.issue_rd];
    assign cnt_dec = wr_valid & pending_q[rf.rw]
                     & ~(set_valid && (rf.issue_rd == rf.rw));

    assign pending_cnt_d = pending_cnt_q + cnt_t'(cnt_inc) - cnt_t'(cnt_dec);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending_q     <= '0;
            pending_cnt_q <= '0;
        end else begin
            pending_q     <= pending_d;
            pending_cnt_q <= pending_cnt_d;
        end
    end

    assign rf.pending_cnt = pending_cnt_q;

endmodule : regfile_scoreboard
